// File: rtl/matmul_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : matmul_pkg                                                    |
// | Purpose  : Shared types and constants for the matrix-multiply sequencer. |
// |            Holds the FSM state encoding and the default index width.     |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package matmul_pkg;

  // Default width of every dimension and index.
  localparam int DIM_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage : matmul_pkg
`default_nettype wire

// File: rtl/matmul_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : matmul_sequencer_if                                           |
// | Purpose  : Control/address bundle between a host and matmul_sequencer.   |
// | Ports    : master drives start, abort, dim_m/n/p (and stall);            |
// |            slave drives busy, done, acc_en, acc_clr, c_wr and the        |
// |            a_row/a_col/b_row/b_col/c_row/c_col addresses.                |
// | Config   : MATMUL_SEQ_STALL_EN adds the stall signal.                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface matmul_sequencer_if
  import matmul_pkg::*;
#(
  parameter int DIM_W = DIM_W_DEFAULT
);

  logic             start;
  logic             abort;
  logic [DIM_W-1:0] dim_m;
  logic [DIM_W-1:0] dim_n;
  logic [DIM_W-1:0] dim_p;
`ifdef MATMUL_SEQ_STALL_EN
  logic             stall;
`endif
  logic             busy;
  logic             done;
  logic [DIM_W-1:0] a_row;
  logic [DIM_W-1:0] a_col;
  logic [DIM_W-1:0] b_row;
  logic [DIM_W-1:0] b_col;
  logic             acc_en;
  logic             acc_clr;
  logic             c_wr;
  logic [DIM_W-1:0] c_row;
  logic [DIM_W-1:0] c_col;

  modport master (
`ifdef MATMUL_SEQ_STALL_EN
    output stall,
`endif
    output start, abort, dim_m, dim_n, dim_p,
    input  busy, done, a_row, a_col, b_row, b_col,
    input  acc_en, acc_clr, c_wr, c_row, c_col
  );

  modport slave (
`ifdef MATMUL_SEQ_STALL_EN
    input  stall,
`endif
    input  start, abort, dim_m, dim_n, dim_p,
    output busy, done, a_row, a_col, b_row, b_col,
    output acc_en, acc_clr, c_wr, c_row, c_col
  );

endinterface : matmul_sequencer_if
`default_nettype wire

// File: rtl/matmul_sequencer_loop_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : loop_counter                                                  |
// | Purpose  : Index counter 0..limit_i that wraps to 0 after limit_i.       |
// | Ports    : clk, clr_n (async active-low reset), clr_i (sync clear,       |
// |            wins over en_i), en_i (advance), limit_i (last value),        |
// |            count_o (current index), tc_o (count_o == limit_i).           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module loop_counter
  import matmul_pkg::*;
#(
  parameter int DIM_W = DIM_W_DEFAULT
) (
  input  wire logic             clk,
  input  wire logic             clr_n,
  input  wire logic             clr_i,
  input  wire logic             en_i,
  input  wire logic [DIM_W-1:0] limit_i,
  output logic      [DIM_W-1:0] count_o,
  output logic                  tc_o
);

  logic [DIM_W-1:0] count_q;
  logic [DIM_W-1:0] count_d;

  assign tc_o    = (count_q == limit_i);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = tc_o ? '0 : count_q + DIM_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : loop_counter
`default_nettype wire

// File: rtl/matmul_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : matmul_sequencer                                              |
// | Purpose  : Walks C[i][j] = sum_k A[i][k]*B[k][j] for an m x n result     |
// |            with inner dimension p: p MAC cycles then one WRITE cycle per |
// |            element, then a one-cycle DONE pulse.                         |
// | Ports    : clk, clr_n (async active-low reset),                          |
// |            bus (matmul_sequencer_if.slave): start/abort/dims in,         |
// |            busy/done/strobes/addresses out.                              |
// | Config   : MATMUL_SEQ_STALL_EN - adds bus.stall; when high in MAC/WRITE  |
// |            the FSM and indices hold and strobes are suppressed.          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int DIM_W = DIM_W_DEFAULT
) (
  input wire logic         clk,
  input wire logic         clr_n,
  matmul_sequencer_if.slave bus
);

  localparam logic [DIM_W-1:0] C_ONE = DIM_W'(1);

  state_e           state_q;
  state_e           state_d;
  logic [DIM_W-1:0] dim_m_q;
  logic [DIM_W-1:0] dim_n_q;
  logic [DIM_W-1:0] dim_p_q;

  logic [DIM_W-1:0] i_cnt;
  logic [DIM_W-1:0] j_cnt;
  logic [DIM_W-1:0] k_cnt;
  logic             i_tc;
  logic             j_tc;
  logic             k_tc;

  logic stall;
  logic accept;
  logic any_zero;
  logic last_elem;
  logic adv_k;
  logic adv_j;
  logic adv_i;

`ifdef MATMUL_SEQ_STALL_EN
  assign stall = bus.stall;
`else
  assign stall = 1'b0;
`endif

  assign accept    = (state_q == ST_IDLE) && bus.start;
  assign any_zero  = (bus.dim_m == '0) || (bus.dim_n == '0) || (bus.dim_p == '0);
  assign last_elem = i_tc && j_tc;

  // k wraps to 0 on the MAC step that leaves for WRITE, so it is already
  // cleared while the WRITE cycle is on the bus.
  assign adv_k = (state_q == ST_MAC) && !stall && !bus.abort;
  // The final element does not advance i/j, so they hold (m-1, n-1) in DONE.
  assign adv_j = (state_q == ST_WRITE) && !stall && !bus.abort && !last_elem;
  assign adv_i = adv_j && j_tc;

  // Dimensions are only sampled at start accept; later changes are ignored.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      dim_m_q <= '0;
      dim_n_q <= '0;
      dim_p_q <= '0;
    end else if (accept) begin
      dim_m_q <= bus.dim_m;
      dim_n_q <= bus.dim_n;
      dim_p_q <= bus.dim_p;
    end
  end

  loop_counter #(.DIM_W(DIM_W)) u_cnt_i (
    .clk     (clk),
    .clr_n   (clr_n),
    .clr_i   (accept),
    .en_i    (adv_i),
    .limit_i (dim_m_q - C_ONE),
    .count_o (i_cnt),
    .tc_o    (i_tc)
  );

  loop_counter #(.DIM_W(DIM_W)) u_cnt_j (
    .clk     (clk),
    .clr_n   (clr_n),
    .clr_i   (accept),
    .en_i    (adv_j),
    .limit_i (dim_n_q - C_ONE),
    .count_o (j_cnt),
    .tc_o    (j_tc)
  );

  loop_counter #(.DIM_W(DIM_W)) u_cnt_k (
    .clk     (clk),
    .clr_n   (clr_n),
    .clr_i   (accept),
    .en_i    (adv_k),
    .limit_i (dim_p_q - C_ONE),
    .count_o (k_cnt),
    .tc_o    (k_tc)
  );

  // State register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: abort beats stall, stall beats normal progress.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = any_zero ? ST_DONE : ST_MAC;
        end
      end
      ST_MAC: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (!stall && k_tc) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (!stall) begin
          state_d = last_elem ? ST_DONE : ST_MAC;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs. Strobes are Moore-style except for stall suppression; an abort
  // in DONE cancels the pulse so an aborted run never reports completion.
  always_comb begin
    bus.busy    = (state_q != ST_IDLE);
    bus.acc_en  = (state_q == ST_MAC) && !stall;
    bus.acc_clr = (state_q == ST_MAC) && !stall && (k_cnt == '0);
    bus.c_wr    = (state_q == ST_WRITE) && !stall;
    bus.done    = (state_q == ST_DONE) && !bus.abort;
  end

  assign bus.a_row = i_cnt;
  assign bus.a_col = k_cnt;
  assign bus.b_row = k_cnt;
  assign bus.b_col = j_cnt;
  assign bus.c_row = i_cnt;
  assign bus.c_col = j_cnt;

endmodule : matmul_sequencer
`default_nettype wire

// File: tb/tb_matmul_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_matmul_sequencer                                           |
// | Purpose  : Directed self-checking bench for matmul_sequencer.            |
// | Config   : MATMUL_SEQ_STALL_EN enables the stall scenario.               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_matmul_sequencer;
  import matmul_pkg::*;

  localparam int DW = 4;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  matmul_sequencer_if #(.DIM_W(DW)) bus ();

  matmul_sequencer #(.DIM_W(DW)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Observations collected by run_and_observe.
  int mon_done_cyc;
  int mon_acc;
  int mon_clr;
  int mon_wr;
  int mon_excl;
  int mon_clrbad;
  int mon_stallbad;
  int mon_done_row;
  int mon_done_col;
  int wr_row [256];
  int wr_col [256];

  // Starts a run and records strobes until done or the cycle budget expires.
  // Cycle 1 is the first cycle after the accepting edge.
  task automatic run_and_observe(input int m, input int n, input int p,
                                 input bit noise, input int stall_at,
                                 input int budget);
    int snap_a;
    int snap_b;
    int snap_r;
    mon_done_cyc = -1; mon_acc = 0; mon_clr = 0; mon_wr = 0;
    mon_excl = 0; mon_clrbad = 0; mon_stallbad = 0;
    mon_done_row = -1; mon_done_col = -1;
    snap_a = 0; snap_b = 0; snap_r = 0;
    @(negedge clk);
    bus.dim_m = DW'(m); bus.dim_n = DW'(n); bus.dim_p = DW'(p);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      if ((int'(bus.acc_en) + int'(bus.c_wr) + int'(bus.done)) > 1) mon_excl++;
      if (bus.acc_clr !== (bus.acc_en && (bus.a_col == '0))) mon_clrbad++;
      if (bus.a_col !== bus.b_row) mon_clrbad++;
      if (bus.acc_en) mon_acc++;
      if (bus.acc_clr) mon_clr++;
      if (bus.c_wr) begin
        if (mon_wr < 256) begin
          wr_row[mon_wr] = int'(bus.c_row);
          wr_col[mon_wr] = int'(bus.c_col);
        end
        mon_wr++;
      end
      if (bus.done) begin
        mon_done_cyc = cyc;
        mon_done_row = int'(bus.c_row);
        mon_done_col = int'(bus.c_col);
        break;
      end
`ifdef MATMUL_SEQ_STALL_EN
      if (stall_at > 0 && cyc == stall_at) begin
        snap_a = int'(bus.a_col); snap_b = int'(bus.b_col); snap_r = int'(bus.a_row);
        bus.stall = 1'b1;
      end
      if (stall_at > 0 && cyc > stall_at && cyc <= stall_at + 3) begin
        if (bus.acc_en || bus.c_wr) mon_stallbad++;
        if (int'(bus.a_col) != snap_a || int'(bus.b_col) != snap_b ||
            int'(bus.a_row) != snap_r) mon_stallbad++;
        if (cyc == stall_at + 3) bus.stall = 1'b0;
      end
`else
      if (stall_at < 0) mon_stallbad++;
`endif
      if (noise) begin
        bus.start = cyc[0];
        bus.dim_m = DW'($urandom_range(1, 15));
        bus.dim_n = DW'($urandom_range(0, 15));
        bus.dim_p = DW'($urandom_range(0, 15));
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.acc_en !== 1'b0 ||
        bus.acc_clr !== 1'b0 || bus.c_wr !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes busy=%b done=%b acc_en=%b acc_clr=%b c_wr=%b required all 0",
               bus.busy, bus.done, bus.acc_en, bus.acc_clr, bus.c_wr);
    end
    checks++;
    if ({bus.a_row, bus.a_col, bus.b_row, bus.b_col, bus.c_row, bus.c_col} !== '0) begin
      errors++;
      $display("FAIL reset_addr a_row=%0d a_col=%0d b_row=%0d b_col=%0d c_row=%0d c_col=%0d required 0",
               bus.a_row, bus.a_col, bus.b_row, bus.b_col, bus.c_row, bus.c_col);
    end
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_run_2x2x3();
    int exp_r [4] = '{0, 0, 1, 1};
    int exp_c [4] = '{0, 1, 0, 1};
    int bad;
    run_and_observe(2, 2, 3, 1'b0, 0, 200);
    checks++;
    if (mon_done_cyc != 17) begin
      errors++; $display("FAIL r223_done_cycle got %0d required 17", mon_done_cyc);
    end
    checks++;
    if (mon_wr != 4) begin
      errors++; $display("FAIL r223_writes got %0d required 4", mon_wr);
    end
    bad = 0;
    for (int w = 0; w < 4; w++) if (wr_row[w] != exp_r[w] || wr_col[w] != exp_c[w]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL r223_write_addr wrong addresses %0d required 0", bad);
    end
    checks++;
    if (mon_acc != 12 || mon_clr != 4 || mon_clrbad != 0) begin
      errors++;
      $display("FAIL r223_mac acc=%0d clr=%0d clrbad=%0d required 12 4 0", mon_acc, mon_clr, mon_clrbad);
    end
    checks++;
    if (mon_excl != 0) begin
      errors++; $display("FAIL r223_exclusive overlaps %0d required 0", mon_excl);
    end
    checks++;
    if (mon_done_row != 1 || mon_done_col != 1) begin
      errors++;
      $display("FAIL r223_hold_idx done at (%0d,%0d) required (1,1)", mon_done_row, mon_done_col);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL r223_idle busy=%b done=%b required 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_run_1x1x1();
    run_and_observe(1, 1, 1, 1'b0, 0, 50);
    checks++;
    if (mon_done_cyc != 3 || mon_acc != 1 || mon_clr != 1) begin
      errors++;
      $display("FAIL r111 done=%0d acc=%0d clr=%0d required 3 1 1", mon_done_cyc, mon_acc, mon_clr);
    end
    checks++;
    if (mon_wr != 1 || wr_row[0] != 0 || wr_col[0] != 0) begin
      errors++;
      $display("FAIL r111_write n=%0d at (%0d,%0d) required 1 at (0,0)", mon_wr, wr_row[0], wr_col[0]);
    end
  endtask

  task automatic test_zero_dim();
    run_and_observe(3, 3, 0, 1'b0, 0, 50);
    checks++;
    if (mon_done_cyc != 1 || mon_acc != 0 || mon_wr != 0) begin
      errors++;
      $display("FAIL zero_p done=%0d acc=%0d wr=%0d required 1 0 0", mon_done_cyc, mon_acc, mon_wr);
    end
  endtask

  task automatic test_full_size();
    int bad;
    run_and_observe(15, 15, 15, 1'b0, 0, 5000);
    checks++;
    if (mon_done_cyc != 3601 || mon_wr != 225) begin
      errors++;
      $display("FAIL r15_count done=%0d wr=%0d required 3601 225", mon_done_cyc, mon_wr);
    end
    checks++;
    if (wr_row[14] != 0 || wr_col[14] != 14 || wr_row[15] != 1 || wr_col[15] != 0) begin
      errors++;
      $display("FAIL r15_wrap w14=(%0d,%0d) w15=(%0d,%0d) required (0,14) (1,0)",
               wr_row[14], wr_col[14], wr_row[15], wr_col[15]);
    end
    bad = 0;
    for (int w = 0; w < 225; w++) if (wr_row[w] != w / 15 || wr_col[w] != w % 15) bad++;
    checks++;
    if (bad != 0 || mon_excl != 0 || mon_clrbad != 0) begin
      errors++;
      $display("FAIL r15_order bad=%0d excl=%0d clrbad=%0d required 0 0 0", bad, mon_excl, mon_clrbad);
    end
  endtask

  // start pulses and changing dims while busy must not disturb the run.
  task automatic test_busy_ignore();
    run_and_observe(2, 2, 3, 1'b1, 0, 200);
    checks++;
    if (mon_done_cyc != 17 || mon_wr != 4 || mon_acc != 12) begin
      errors++;
      $display("FAIL busy_ignore done=%0d wr=%0d acc=%0d required 17 4 12", mon_done_cyc, mon_wr, mon_acc);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL busy_ignore_idle busy=%b required 0", bus.busy);
    end
  endtask

  task automatic test_abort();
    int nwr;
    bit seen_done;
    bit hit;
    nwr = 0; seen_done = 1'b0; hit = 1'b0;
    @(negedge clk);
    bus.dim_m = 4'd2; bus.dim_n = 4'd2; bus.dim_p = 4'd2; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (bus.done) seen_done = 1'b1;
      if (bus.c_wr) nwr++;
      if (bus.c_wr && nwr == 2) begin
        hit = 1'b1;
        bus.abort = 1'b1; bus.start = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!hit || seen_done) begin
      errors++; $display("FAIL abort_reach second_write=%0d early_done=%0d required 1 0", hit, seen_done);
    end
    @(negedge clk);
    bus.abort = 1'b0; bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.c_wr !== 1'b0 || bus.acc_en !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle busy=%b done=%b c_wr=%b acc_en=%b required 0 0 0 0",
               bus.busy, bus.done, bus.c_wr, bus.acc_en);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL abort_start_ignored busy=%b done=%b required 0 0", bus.busy, bus.done);
    end
    run_and_observe(2, 2, 2, 1'b0, 0, 100);
    checks++;
    if (mon_done_cyc != 13 || mon_wr != 4 || wr_row[0] != 0 || wr_col[0] != 0) begin
      errors++;
      $display("FAIL abort_rerun done=%0d wr=%0d first=(%0d,%0d) required 13 4 (0,0)",
               mon_done_cyc, mon_wr, wr_row[0], wr_col[0]);
    end
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    bus.dim_m = 4'd2; bus.dim_n = 4'd2; bus.dim_p = 4'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    // Cycle 6: MAC for element (0,1) with k=1.
    checks++;
    if (bus.acc_en !== 1'b1 || bus.a_col !== 4'd1 || bus.b_col !== 4'd1) begin
      errors++;
      $display("FAIL midrun_pre acc_en=%b k=%0d j=%0d required 1 1 1", bus.acc_en, bus.a_col, bus.b_col);
    end
    #2 clr_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.acc_en !== 1'b0 || bus.acc_clr !== 1'b0 || bus.c_wr !== 1'b0 ||
        bus.done !== 1'b0 || bus.a_col !== 4'd0 || bus.b_col !== 4'd0 || bus.a_row !== 4'd0) begin
      errors++;
      $display("FAIL midrun_async busy=%b acc_en=%b c_wr=%b done=%b k=%0d j=%0d i=%0d required all 0",
               bus.busy, bus.acc_en, bus.c_wr, bus.done, bus.a_col, bus.b_col, bus.a_row);
    end
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL midrun_after busy=%b required 0", bus.busy);
    end
    run_and_observe(1, 1, 1, 1'b0, 0, 50);
    checks++;
    if (mon_done_cyc != 3 || mon_wr != 1) begin
      errors++; $display("FAIL midrun_fresh done=%0d wr=%0d required 3 1", mon_done_cyc, mon_wr);
    end
  endtask

`ifdef MATMUL_SEQ_STALL_EN
  task automatic test_stall();
    run_and_observe(2, 2, 3, 1'b0, 2, 200);
    checks++;
    if (mon_done_cyc != 20 || mon_wr != 4) begin
      errors++; $display("FAIL stall_latency done=%0d wr=%0d required 20 4", mon_done_cyc, mon_wr);
    end
    checks++;
    if (mon_stallbad != 0 || mon_excl != 0) begin
      errors++; $display("FAIL stall_frozen bad=%0d excl=%0d required 0 0", mon_stallbad, mon_excl);
    end
  endtask
`endif

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.dim_m = '0;
    bus.dim_n = '0;
    bus.dim_p = '0;
`ifdef MATMUL_SEQ_STALL_EN
    bus.stall = 1'b0;
`endif
    test_reset();
    test_run_2x2x3();
    test_run_1x1x1();
    test_zero_dim();
    test_full_size();
    test_busy_ignore();
    test_abort();
    test_reset_midrun();
`ifdef MATMUL_SEQ_STALL_EN
    test_stall();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_matmul_sequencer
`default_nettype wire

// File: doc/matmul_sequencer.md
MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 Parameter DIM_W, default 4: width of every dimension and index; max dimension 2**DIM_W-1.
REQ-002 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 Port clr_n  input  1: reset, asynchronous and active-low.
REQ-004 Port start  input  1: request to run one matrix multiply; sampled only in IDLE.
REQ-005 Port abort  input  1: synchronous cancel of a run in progress.
REQ-006 Port dim_m, dim_n, dim_p  input  DIM_W each: rows of A, columns of B, inner dimension; latched on start accept.
REQ-007 Port busy  output  1: high in every state except IDLE.
REQ-008 Port done  output  1: one-cycle pulse at run completion.
REQ-009 Port a_row, a_col, b_row, b_col  output  DIM_W each: operand addresses (i, k, k, j).
REQ-010 Port acc_en  output  1: MAC accumulate strobe. Port acc_clr  output  1: MAC loads the product instead of adding it.
REQ-011 Port c_wr  output  1: result write strobe. Port c_row, c_col  output  DIM_W each: result address (i, j).

Function
REQ-012 FSM states: IDLE, MAC, WRITE, DONE; state, i, j and k are registers.
REQ-013 IDLE with start=1: latch dims, clear i/j/k, go to MAC; if any dim is 0, go to DONE with no MAC or WRITE cycles.
REQ-014 MAC: acc_en=1, acc_clr=(k==0); k increments per cycle; at k==dim_p-1 go to WRITE.
REQ-015 WRITE: c_wr=1 for exactly one cycle, c_row=i, c_col=j; k cleared.
REQ-016 WRITE, next element: j increments; at j==dim_n-1, j wraps to 0 and i increments; at i==dim_m-1 and j==dim_n-1, go to DONE, else go to MAC.
REQ-017 DONE: done=1 for one cycle, then IDLE; indices hold their final values.
REQ-018 Cycle count from start-accept edge to done inclusive SHALL be dim_m*dim_n*(dim_p+1)+1.
REQ-019 Address outputs SHALL be combinational from index registers and valid whenever acc_en or c_wr is high.
REQ-020 start while busy SHALL be ignored; dims changing mid-run SHALL have no effect.
REQ-021 abort=1 in MAC/WRITE/DONE: next state IDLE, no done pulse, strobes low from the next cycle; abort has priority over all other transitions; abort in IDLE SHALL be ignored.
REQ-022 acc_en, c_wr and done SHALL be mutually exclusive in every cycle.

Reset
REQ-023 clr_n=0 SHALL immediately force state=IDLE and i=j=k=0; outputs busy=done=acc_en=acc_clr=c_wr=0 and all addresses 0.
REQ-024 Reset asserted mid-run SHALL discard the run; the first start after clr_n rises begins a fresh run.

Configuration
REQ-025 Macro MATMUL_SEQ_STALL_EN defined: extra port stall input 1; stall=1 in MAC/WRITE holds state and indices and forces acc_en=c_wr=0; abort still overrides stall.
REQ-026 Macro MATMUL_SEQ_STALL_EN undefined: stall port absent; behaviour as if stall were tied to 0.

Structure
REQ-027 Shared package matmul_pkg SHALL hold the FSM state typedef and the DIM_W default constant.
REQ-028 Indices SHALL be built from three instances of one sub-module, loop_counter (clear, enable, limit inputs; terminal-count output; wraps to 0).

Verification
REQ-029 Run m=2, n=2, p=3 -> 4 writes at (0,0),(0,1),(1,0),(1,1); acc_clr only on k=0; done exactly 17 cycles after accept.
REQ-030 Run m=1, n=1, p=1 -> one MAC cycle with acc_clr=1, one write at (0,0), done on cycle 3.
REQ-031 Run with dim_p=0 (m=3, n=3) -> no acc_en, no c_wr; done on cycle 1 after accept.
REQ-032 Run m=15, n=15, p=15 -> 225 writes; j wraps 14->0 with i incrementing; done at cycle 3601.
REQ-033 Run m=2, n=2, p=2, abort during second WRITE, start re-pulsed in same cycle -> IDLE next cycle, no done pulse, start ignored; new start one cycle later runs cleanly.
REQ-034 clr_n low mid-MAC, then stall=1 for 3 cycles with MATMUL_SEQ_STALL_EN -> outputs 0 during reset; during stall indices frozen, no strobes; total latency extended by exactly 3 cycles.
